copy_ctrl: RTL
==============

COPY_CTRL -- requirements
Module: copy_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, transfer length width in beats.
REQ-003 SHALL have parameter BEAT_SHIFT, default 2, log2 of bytes per beat.
REQ-004 SHALL have parameter MAX_BURST_LOG2, default 4 (bursts of 1..16 beats), legal range 0..8.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 8, maximum unacknowledged write bursts.
REQ-006 SHALL have ports: clk, input, 1, the only clock; rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports: i_start in 1; i_rd_base in ADDR_WIDTH; i_wr_base in ADDR_WIDTH; i_num_beats in CNT_WIDTH; i_burst_len in MAX_BURST_LOG2+1 (beats per burst).
REQ-008 SHALL have ports: o_busy out 1; o_done out 1; o_err out 1.
REQ-009 SHALL have ports: o_rd_addr_vld out 1; o_rd_addr out ADDR_WIDTH; o_rd_addr_len out 8 (beats-1); i_rd_addr_rdy in 1.
REQ-010 SHALL have ports: o_wr_addr_vld out 1; o_wr_addr out ADDR_WIDTH; o_wr_addr_len out 8 (beats-1); i_wr_addr_rdy in 1; i_wr_resp_vld in 1; i_wr_resp_err in 1.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE; o_busy=1 only in RUN; o_done=1 only in DONE.
REQ-012 SHALL, on i_start in IDLE or DONE, latch i_rd_base, i_wr_base, i_num_beats, effective burst length; clear o_err; enter RUN next cycle (DONE if i_num_beats==0).
REQ-013 SHALL ignore i_start while in RUN.
REQ-014 SHALL clamp effective burst length: i_burst_len==0 -> 1; i_burst_len > 2^MAX_BURST_LOG2 -> 2^MAX_BURST_LOG2.
REQ-015 SHALL size each burst as min(effective burst length, remaining beats) of its channel; o_*_addr_len = size-1, zero-extended.
REQ-016 SHALL drive o_rd_addr = rd_base + (rd_beats_issued << BEAT_SHIFT), modulo 2^ADDR_WIDTH; o_wr_addr likewise from wr_base; no 4 KB boundary splitting.
REQ-017 SHALL assert o_rd_addr_vld in RUN while read beats remain; fire = vld && rdy; counters advance only on fire.
REQ-018 SHALL assert o_wr_addr_vld in RUN while write beats remain and outstanding < MAX_OUTSTANDING.
REQ-019 SHALL keep address, len, vld stable from vld assertion until fire (outstanding only decreases without a fire).
REQ-020 SHALL run read and write channels independently; write issue SHALL NOT wait for reads.
REQ-021 SHALL increment outstanding on write fire, decrement on i_wr_resp_vld, unchanged when both in the same cycle.
REQ-022 SHALL ignore i_wr_resp_vld when outstanding==0 and no write fire that cycle (no underflow), and set o_err.
REQ-023 SHALL set o_err sticky on i_wr_resp_vld && i_wr_resp_err; transfer SHALL continue to completion.
REQ-024 SHALL go RUN -> DONE the cycle after all read bursts fired, all write bursts fired, outstanding==0.
REQ-025 SHALL hold DONE (o_done=1) until the next i_start.

Reset
REQ-026 SHALL, on rst sampled high at clk edge, enter IDLE, zero all counters and latched config, drive every output 0.
REQ-027 SHALL treat rst mid-RUN as abort: valids low the cycle after reset, pending responses forgotten.

Verification
REQ-028 num_beats=40, burst=16, rd_base=0x0, wr_base=0x1000, rdy=1 -> read bursts 0x0/len15, 0x40/len15, 0x80/len7; writes 0x1000, 0x1040, 0x1080; 3 resps -> o_done.
REQ-029 burst=0 and burst=31 (MAX_BURST_LOG2=4), num_beats=3 -> len 0 three bursts; len 2 one burst.
REQ-030 MAX_OUTSTANDING=2, num_beats=64, burst=4, no resps -> exactly 2 write fires, vld drops; one resp -> one more fire; resp+fire same cycle keeps count 2.
REQ-031 rd_base=0xFFFFFFF8, num_beats=4, burst=1 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-032 resp with err=1 mid-transfer -> o_err=1, o_done still reached; next i_start clears o_err; spurious resp in IDLE -> o_err=1, no count change.
REQ-033 rst mid-RUN with rdy=0 -> both valids 0 next cycle; num_beats=0 start -> o_done next cycle, no valids.

Source files
------------

// File: rtl/copy_ctrl.sv
// copy_ctrl: issues read and write address bursts for a linear memory copy,
// tracks unacknowledged write bursts, and reports busy/done/error status.
module copy_ctrl #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned CNT_WIDTH       = 16,
   parameter int unsigned BEAT_SHIFT      = 2,
   parameter int unsigned MAX_BURST_LOG2  = 4,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic [ADDR_WIDTH-1:0]   i_rd_base,
   input  logic [ADDR_WIDTH-1:0]   i_wr_base,
   input  logic [CNT_WIDTH-1:0]    i_num_beats,
   input  logic [MAX_BURST_LOG2:0] i_burst_len,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err,
   output logic                    o_rd_addr_vld,
   output logic [ADDR_WIDTH-1:0]   o_rd_addr,
   output logic [7:0]              o_rd_addr_len,
   input  logic                    i_rd_addr_rdy,
   output logic                    o_wr_addr_vld,
   output logic [ADDR_WIDTH-1:0]   o_wr_addr,
   output logic [7:0]              o_wr_addr_len,
   input  logic                    i_wr_addr_rdy,
   input  logic                    i_wr_resp_vld,
   input  logic                    i_wr_resp_err
);

   localparam int unsigned BL_W      = MAX_BURST_LOG2 + 1;
   localparam int unsigned MAX_BURST = 1 << MAX_BURST_LOG2;
   localparam int unsigned SZ_W      = (CNT_WIDTH > BL_W) ? CNT_WIDTH : BL_W;
   localparam int unsigned OUT_W     = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_base_q, rd_base_d;
   logic [ADDR_WIDTH-1:0] wr_base_q, wr_base_d;
   logic [CNT_WIDTH-1:0]  num_q, num_d;
   logic [BL_W-1:0]       burst_q, burst_d;
   logic [CNT_WIDTH-1:0]  rd_issued_q, rd_issued_d;
   logic [CNT_WIDTH-1:0]  wr_issued_q, wr_issued_d;
   logic [OUT_W-1:0]      outst_q, outst_d;
   logic                  err_q, err_d;

   logic [BL_W-1:0]       eff_burst;
   logic [CNT_WIDTH-1:0]  rd_rem, wr_rem;
   logic [SZ_W-1:0]       rd_size, wr_size;
   logic                  run, rd_vld, wr_vld, rd_fire, wr_fire, spurious, accept;

   // Clamp the requested burst length into 1..2^MAX_BURST_LOG2.
   always_comb begin
      eff_burst = i_burst_len;
      if (i_burst_len == '0) begin
         eff_burst = BL_W'(1);
      end else if (i_burst_len > BL_W'(MAX_BURST)) begin
         eff_burst = BL_W'(MAX_BURST);
      end
   end

   // Burst sizing per channel: min(effective burst, remaining beats).
   always_comb begin
      rd_rem  = num_q - rd_issued_q;
      wr_rem  = num_q - wr_issued_q;
      rd_size = (SZ_W'(burst_q) < SZ_W'(rd_rem)) ? SZ_W'(burst_q) : SZ_W'(rd_rem);
      wr_size = (SZ_W'(burst_q) < SZ_W'(wr_rem)) ? SZ_W'(burst_q) : SZ_W'(wr_rem);
   end

   assign run      = (state_q == StRun);
   assign rd_vld   = run && (rd_rem != '0);
   // Outstanding only rises on a fire, so a raised write valid cannot drop before it fires.
   assign wr_vld   = run && (wr_rem != '0) && (outst_q < OUT_W'(MAX_OUTSTANDING));
   assign rd_fire  = rd_vld && i_rd_addr_rdy;
   assign wr_fire  = wr_vld && i_wr_addr_rdy;
   assign spurious = i_wr_resp_vld && !wr_fire && (outst_q == '0);
   assign accept   = i_start && (state_q != StRun);

   // Next-state: FSM, config latch, issue counters, outstanding count, sticky error.
   always_comb begin
      state_d     = state_q;
      rd_base_d   = rd_base_q;
      wr_base_d   = wr_base_q;
      num_d       = num_q;
      burst_d     = burst_q;
      rd_issued_d = rd_issued_q;
      wr_issued_d = wr_issued_q;
      outst_d     = outst_q;
      err_d       = err_q;

      if (rd_fire) rd_issued_d = rd_issued_q + CNT_WIDTH'(rd_size);
      if (wr_fire) wr_issued_d = wr_issued_q + CNT_WIDTH'(wr_size);

      if (wr_fire && !i_wr_resp_vld) begin
         outst_d = outst_q + OUT_W'(1);
      end else if (!wr_fire && i_wr_resp_vld && (outst_q != '0)) begin
         outst_d = outst_q - OUT_W'(1);
      end

      if ((i_wr_resp_vld && i_wr_resp_err) || spurious) err_d = 1'b1;

      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               rd_base_d   = i_rd_base;
               wr_base_d   = i_wr_base;
               num_d       = i_num_beats;
               burst_d     = eff_burst;
               rd_issued_d = '0;
               wr_issued_d = '0;
               err_d       = 1'b0;
               state_d     = (i_num_beats == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if ((rd_issued_d == num_q) && (wr_issued_d == num_q) && (outst_d == '0)) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous reset; reset also forgets pending responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rd_base_q   <= '0;
         wr_base_q   <= '0;
         num_q       <= '0;
         burst_q     <= '0;
         rd_issued_q <= '0;
         wr_issued_q <= '0;
         outst_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_base_q   <= rd_base_d;
         wr_base_q   <= wr_base_d;
         num_q       <= num_d;
         burst_q     <= burst_d;
         rd_issued_q <= rd_issued_d;
         wr_issued_q <= wr_issued_d;
         outst_q     <= outst_d;
         err_q       <= err_d;
      end
   end

   // Outputs; address and length are forced to zero outside RUN.
   always_comb begin
      o_busy        = run;
      o_done        = (state_q == StDone);
      o_err         = err_q;
      o_rd_addr_vld = rd_vld;
      o_wr_addr_vld = wr_vld;
      o_rd_addr     = '0;
      o_wr_addr     = '0;
      o_rd_addr_len = '0;
      o_wr_addr_len = '0;
      if (run) begin
         o_rd_addr = rd_base_q + (ADDR_WIDTH'(rd_issued_q) << BEAT_SHIFT);
         o_wr_addr = wr_base_q + (ADDR_WIDTH'(wr_issued_q) << BEAT_SHIFT);
         if (rd_size != '0) o_rd_addr_len = 8'(rd_size - SZ_W'(1));
         if (wr_size != '0) o_wr_addr_len = 8'(wr_size - SZ_W'(1));
      end
   end

endmodule
